// File: rtl/pic_priority_core_if.sv
// CPU-side handshake bundle of the interrupt controller: INT/ACK/vector plus EOI commands.
interface pic_priority_core_if #(
  parameter int ID_W  = 3,
  parameter int VEC_W = 8
);
  logic             int_out;
  logic             ack;
  logic             vector_valid;
  logic [VEC_W-1:0] vector;
  logic             eoi_valid;
  logic             eoi_specific;
  logic [ID_W-1:0]  eoi_id;

  // CPU-interface block
  modport master (
    input  int_out, vector_valid, vector,
    output ack, eoi_valid, eoi_specific, eoi_id
  );

  // interrupt controller core
  modport slave (
    output int_out, vector_valid, vector,
    input  ack, eoi_valid, eoi_specific, eoi_id
  );
endinterface

// File: rtl/pic_priority_core.sv
// Interrupt controller core: request latching, masking, rotating priority,
// in-service nesting and the INT/ACK/vector handshake.
//
// state | meaning
// IDLE  | no request presented to the CPU
// REQ   | int_out high, waiting for ack
// VEC   | vector strobe cycle; auto-EOI applied here
module pic_priority_core #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [VEC_W-1:0]   vector_base,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               rotate_on_eoi,
  input  logic               auto_eoi,
  pic_priority_core_if.slave cpu,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr
);

  typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [ID_W-1:0]    lowest_prio, lowest_prio_n;
  logic [NUM_IRQ-1:0] irr_n, isr_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic               spur_q, spur_n;
  logic               int_q, vv_q;
  logic [VEC_W-1:0]   vector_q, vector_n;

  // Returns {found, rank, id} of the best-ranked set bit of v; rank 0 is the
  // channel just after lp.
  function automatic logic [2*ID_W:0] best_of(input logic [NUM_IRQ-1:0] v,
                                               input logic [ID_W-1:0] lp);
    logic            found;
    logic [ID_W-1:0] id, rank, idx;
    int              tmp;
    found = 1'b0;
    id    = '0;
    rank  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      tmp = int'(lp) + 1 + k;
      if (tmp >= NUM_IRQ) tmp = tmp - NUM_IRQ;
      idx = ID_W'(tmp);
      if (v[idx]) begin
        found = 1'b1;
        id    = idx;
        rank  = ID_W'(k);
      end
    end
    return {found, rank, id};
  endfunction

  logic [2*ID_W:0]    isr_best, cand, isr_a_best;
  logic               eoi_hit, cand_ok, ack_take;
  logic [ID_W-1:0]    eoi_target;
  logic [NUM_IRQ-1:0] isr_a, isr_b, irr_set;
  logic [ID_W-1:0]    lp_a;

  // EOI first, then auto-EOI, then the ack set; resolve the candidate against post-EOI state.
  always_comb begin
    isr_best   = best_of(isr, lowest_prio);
    eoi_target = cpu.eoi_specific ? cpu.eoi_id : isr_best[ID_W-1:0];
    eoi_hit    = cpu.eoi_valid &&
                 (cpu.eoi_specific ? isr[cpu.eoi_id] : isr_best[2*ID_W]);
    isr_a = isr;
    lp_a  = lowest_prio;
    if (eoi_hit) begin
      isr_a[eoi_target] = 1'b0;
      if (rotate_on_eoi) lp_a = eoi_target;
    end
    isr_b         = isr_a;
    lowest_prio_n = lp_a;
    if (state == VEC && auto_eoi && !spur_q) begin
      isr_b[id_q] = 1'b0;
      if (rotate_on_eoi) lowest_prio_n = id_q;
    end

    cand       = best_of(irr & ~imr, lp_a);
    isr_a_best = best_of(isr_a, lp_a);
    cand_ok    = cand[2*ID_W] &&
                 (!isr_a_best[2*ID_W] ||
                  (cand[2*ID_W-1:ID_W] < isr_a_best[2*ID_W-1:ID_W]));

    irr_set  = level_mode ? irq_in : (irr | (irq_in & ~irq_prev));
    irr_n    = irr_set;
    isr_n    = isr_b;
    id_n     = id_q;
    spur_n   = spur_q;
    vector_n = vector_q;
    ack_take = (state == REQ) && cpu.ack;
    if (ack_take) begin
      if (cand_ok) begin
        id_n   = cand[ID_W-1:0];
        spur_n = 1'b0;
        isr_n[cand[ID_W-1:0]] = 1'b1;
        irr_n[cand[ID_W-1:0]] = 1'b0;
      end else begin
        id_n   = ID_W'(NUM_IRQ - 1);
        spur_n = 1'b1;
      end
      vector_n = vector_base + VEC_W'(id_n);
    end
  end

  // Next-state logic of the handshake FSM.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cand_ok) state_n = REQ;
      REQ:     if (cpu.ack) state_n = VEC;
      VEC:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and all controller storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      irq_prev    <= '0;
      irr         <= '0;
      isr         <= '0;
      imr         <= '1;
      lowest_prio <= ID_W'(NUM_IRQ - 1);
      id_q        <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      vv_q        <= 1'b0;
      vector_q    <= '0;
    end else begin
      state       <= state_n;
      irq_prev    <= irq_in;
      irr         <= irr_n;
      isr         <= isr_n;
      if (mask_we) imr <= mask_wdata;
      lowest_prio <= lowest_prio_n;
      id_q        <= id_n;
      spur_q      <= spur_n;
      int_q       <= (state_n == REQ);
      vv_q        <= (state_n == VEC);
      vector_q    <= vector_n;
    end
  end

  assign cpu.int_out      = int_q;
  assign cpu.vector_valid = vv_q;
  assign cpu.vector       = vector_q;

endmodule
